// File: rtl/seg_pkg.sv
// Shared constants, state encoding and glyph lookup for the 7-segment display blocks.
// Glyph codes are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package seg_pkg;

  localparam int NDIG = 6;

  localparam logic [7:0] ZER = 8'hC0;
  localparam logic [7:0] ONE = 8'hF9;
  localparam logic [7:0] TWO = 8'hA4;
  localparam logic [7:0] THR = 8'hB0;
  localparam logic [7:0] FOU = 8'h99;
  localparam logic [7:0] FIV = 8'h92;
  localparam logic [7:0] SIX = 8'h82;
  localparam logic [7:0] SEV = 8'hF8;
  localparam logic [7:0] EIG = 8'h80;
  localparam logic [7:0] NIN = 8'h90;
  localparam logic [7:0] A   = 8'h88;
  localparam logic [7:0] B   = 8'h83;
  localparam logic [7:0] C   = 8'hC6;
  localparam logic [7:0] D   = 8'hA1;
  localparam logic [7:0] E   = 8'h86;
  localparam logic [7:0] F   = 8'h8E;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [5:0] SEL_OFF = 6'h3F;

  typedef enum logic {BLANK, SHOW} state_t;

  // Returns the active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = ZER;
      4'h1: g = ONE;
      4'h2: g = TWO;
      4'h3: g = THR;
      4'h4: g = FOU;
      4'h5: g = FIV;
      4'h6: g = SIX;
      4'h7: g = SEV;
      4'h8: g = EIG;
      4'h9: g = NIN;
      4'hA: g = A;
      4'hB: g = B;
      4'hC: g = C;
      4'hD: g = D;
      4'hE: g = E;
      default: g = F;
    endcase
    return ~g[6:0];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Update channel into the scan controller: value, digit enables and decimal points
// transferred with a valid/ready handshake.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                data_vld;
  logic                data_rdy;
  logic [NDIG*4-1:0]   data_val;
  logic [NDIG-1:0]     data_en;
  logic [NDIG-1:0]     data_dp;

  modport master (
    output data_vld, data_val, data_en, data_dp,
    input  data_rdy
  );

  modport slave (
    input  data_vld, data_val, data_en, data_dp,
    output data_rdy
  );

endinterface

// File: rtl/seg_dec.sv
// Hex nibble plus decimal point to active-low segment pattern {dp,g,f,e,d,c,b,a}.
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = ~{dp, seg7(nib)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode scan controller: double-buffered display value, per-slot
// blanking gap, leading-zero blanking and registered active-low dig/sel drive.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_CYC  = 50_000,
  parameter int BLANK_CYC = 500
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_ctrl_if.slave      bus,
  input  logic                lzb,
  output logic                frame_done,
  output logic [7:0]          dig,
  output logic [NDIG-1:0]     sel
);

  localparam int CW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NDIG - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic                wrap;

  logic [NDIG*4-1:0]   act_val_q, pend_val_q;
  logic [NDIG-1:0]     act_en_q, act_dp_q, pend_en_q, pend_dp_q;
  logic                pend_full_q;
  logic                accept;
  logic                fd_q;

  logic [2:0]          lead_idx;
  logic [3:0]          nib;
  logic                en_b, dp_b, digit_on;
  logic [7:0]          seg_w;
  logic [7:0]          dig_q;
  logic [NDIG-1:0]     sel_q;

  // ---- stage: slot sequencer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (state_q == BLANK) begin
      if (cnt_q == BLANK_LAST) state_d = SHOW;
    end else begin
      if (cnt_q == SCAN_LAST) begin
        cnt_d   = '0;
        state_d = BLANK;
        wrap    = (idx_q == IDX_LAST);
        idx_d   = wrap ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

  // ---- stage: pending/active buffers ----
  assign accept       = bus.data_vld & ~pend_full_q;
  assign bus.data_rdy = ~pend_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full_q <= 1'b0;
      fd_q        <= 1'b0;
      act_val_q   <= '0;
      act_en_q    <= '1;
      act_dp_q    <= '0;
    end else begin
      fd_q <= wrap;
      // Swap only on the frame boundary so a frame never mixes two values.
      if (wrap && pend_full_q) begin
        act_val_q   <= pend_val_q;
        act_en_q    <= pend_en_q;
        act_dp_q    <= pend_dp_q;
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pend_full_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_val_q <= bus.data_val;
      pend_en_q  <= bus.data_en;
      pend_dp_q  <= bus.data_dp;
    end
  end

  // ---- stage: digit select and leading-zero blanking ----
  always_comb begin
    lead_idx = 3'd0;
    for (int i = 1; i < NDIG; i++) begin
      if (act_val_q[i*4 +: 4] != 4'h0) lead_idx = 3'(i);
    end
  end

  always_comb begin
    nib  = act_val_q[3:0];
    en_b = act_en_q[0];
    dp_b = act_dp_q[0];
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == 3'(i)) begin
        nib  = act_val_q[i*4 +: 4];
        en_b = act_en_q[i];
        dp_b = act_dp_q[i];
      end
    end
  end

  // Blanked digits still consume their slot so duty cycle per digit is constant.
  assign digit_on = (state_q == SHOW) && en_b && (!lzb || (idx_q <= lead_idx));

  seg_dec u_dec (
    .nib (nib),
    .dp  (dp_b),
    .seg (seg_w)
  );

  // ---- stage: registered pin drive ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_OFF;
      dig_q <= SEG_OFF;
    end else begin
      sel_q <= digit_on ? ~(6'b1 << idx_q) : SEL_OFF;
      dig_q <= digit_on ? seg_w : SEG_OFF;
    end
  end

  assign sel        = sel_q;
  assign dig        = dig_q;
  assign frame_done = fd_q & ~rst;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-level reference model predicts
// the pins each cycle from elapsed time and the buffered display contents.
module tb_seg_scan_ctrl;

  localparam int SCAN  = 10;
  localparam int BLNK  = 2;
  localparam int FRAME = 6 * SCAN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lzb = 1'b0;
  logic       fd;
  logic [7:0] dig;
  logic [5:0] sel;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SCAN_CYC(SCAN), .BLANK_CYC(BLNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .lzb        (lzb),
    .frame_done (fd),
    .dig        (dig),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [23:0] a_val, p_val;
  logic [5:0]  a_en, a_dp, p_en, p_dp;
  bit          p_full = 0;
  bit          last_acc = 0;
  logic [5:0]  e_sel;
  logic [7:0]  e_dig;
  logic        e_fd;

  // What the pins should show for time p since reset, given the active buffer.
  function automatic void exp_disp(input int p, output logic [5:0] s, output logic [7:0] d);
    int slot;
    int m;
    slot = (p / SCAN) % 6;
    m = 0;
    s = 6'h3F;
    d = 8'hFF;
    for (int i = 0; i < 6; i++) if (a_val[i*4 +: 4] != 4'h0) m = i;
    if ((p % SCAN) >= BLNK && a_en[slot] && (!lzb || slot <= m)) begin
      s = ~(6'b1 << slot);
      d = glyph[a_val[slot*4 +: 4]] & (a_dp[slot] ? 8'h7F : 8'hFF);
    end
  endfunction

  task automatic tick();
    logic [5:0]  s;
    logic [7:0]  d;
    int          p;
    bit          acc;
    logic [23:0] iv;
    logic [5:0]  ie, idp;
    acc = (bus.data_vld === 1'b1) && !p_full && !rst;
    iv  = bus.data_val;
    ie  = bus.data_en;
    idp = bus.data_dp;
    p   = k;
    exp_disp(p, s, d);
    @(posedge clk);
    last_acc = 0;
    if (rst) begin
      k = 0; a_val = '0; a_en = 6'h3F; a_dp = '0; p_full = 0;
      e_sel = 6'h3F; e_dig = 8'hFF; e_fd = 1'b0;
    end else begin
      e_sel = s;
      e_dig = d;
      e_fd  = (p % FRAME == FRAME - 1);
      if (e_fd && p_full) begin
        a_val = p_val; a_en = p_en; a_dp = p_dp; p_full = 0;
      end
      if (acc) begin
        p_val = iv; p_en = ie; p_dp = idp; p_full = 1; last_acc = 1;
      end
      k++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    if (sel !== 6'h3F) begin errors++; $display("FAIL reset_sel got %h exp 3f", sel); end
    if (dig !== 8'hFF) begin errors++; $display("FAIL reset_dig got %h exp ff", dig); end
    if (bus.data_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", bus.data_rdy); end
    if (fd !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", fd); end
    checks += 4;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int nfd = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (sel !== e_sel) begin errors++; $display("FAIL idle_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL idle_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL idle_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL idle_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
      if (fd === 1'b1) nfd++;
    end
    if (nfd !== 2) begin errors++; $display("FAIL idle_fd_count got %0d exp 2", nfd); end
    checks++;
  endtask

  task automatic test_write_midframe();
    int wk = -1;
    for (int c = 0; c < 150; c++) begin
      if (c == 15) begin
        bus.data_vld = 1'b1; bus.data_val = 24'h12AB3F; bus.data_en = 6'h3F; bus.data_dp = 6'b000100;
      end
      tick();
      if (last_acc) begin
        bus.data_vld = 1'b0;
        wk = k;
        if (bus.data_rdy !== 1'b0) begin errors++; $display("FAIL wr_rdy_drop got %b exp 0", bus.data_rdy); end
        checks++;
      end
      if (sel !== e_sel) begin errors++; $display("FAIL wr_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL wr_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL wr_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL wr_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
      // digit 2 keeps showing 0 until the boundary, then B with its decimal point
      if (wk >= 0 && sel === 6'h3B) begin
        if (dig !== ((k > 180) ? 8'h03 : 8'hC0)) begin
          errors++; $display("FAIL wr_digit2 k=%0d got %h exp %h", k, dig, (k > 180) ? 8'h03 : 8'hC0);
        end
        checks++;
      end
    end
    if (wk < 0) begin errors++; $display("FAIL wr_accept got none exp one"); end
    checks++;
  endtask

  task automatic test_lzb();
    lzb = 1'b1;
    bus.data_vld = 1'b1; bus.data_val = 24'h000042; bus.data_en = 6'h3F; bus.data_dp = 6'h3F;
    for (int c = 0; c < 280; c++) begin
      if (c == 150) begin
        bus.data_vld = 1'b1; bus.data_val = 24'h000000; bus.data_en = 6'h3F; bus.data_dp = 6'h00;
      end
      tick();
      if (last_acc) bus.data_vld = 1'b0;
      if (sel !== e_sel) begin errors++; $display("FAIL lzb_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL lzb_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL lzb_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL lzb_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
    end
    lzb = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nacc = 0;
    int stall = 0;
    bus.data_vld = 1'b1; bus.data_val = 24'($urandom); bus.data_en = 6'h3F; bus.data_dp = 6'($urandom);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (last_acc) begin
        nacc++;
        if (nacc == 1) begin bus.data_val = 24'($urandom); bus.data_dp = 6'($urandom); end
        else bus.data_vld = 1'b0;
      end
      if (bus.data_vld === 1'b1 && bus.data_rdy === 1'b0) stall++;
      if (sel !== e_sel) begin errors++; $display("FAIL b2b_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL b2b_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL b2b_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL b2b_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
    end
    if (nacc !== 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", nacc); end
    if (stall == 0) begin errors++; $display("FAIL b2b_stall got %0d exp >0", stall); end
    checks += 2;
  endtask

  task automatic test_en_mask();
    int last = -1;
    int nint = 0;
    bus.data_vld = 1'b1; bus.data_val = 24'($urandom); bus.data_en = 6'b101010; bus.data_dp = 6'($urandom);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (last_acc) bus.data_vld = 1'b0;
      if (sel !== e_sel) begin errors++; $display("FAIL en_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL en_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL en_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL en_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
      if (fd === 1'b1) begin
        if (last >= 0) begin
          nint++;
          if (k - last !== FRAME) begin errors++; $display("FAIL en_frame_len got %0d exp %0d", k - last, FRAME); end
          checks++;
        end
        last = k;
      end
    end
    if (nint < 2) begin errors++; $display("FAIL en_frame_count got %0d exp >=2", nint); end
    checks++;
  endtask

  task automatic test_reset_mid_show();
    bit hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (k % FRAME == 5 && !p_full) begin
        bus.data_vld = 1'b1; bus.data_val = 24'hFEDCBA; bus.data_en = 6'h3F; bus.data_dp = 6'h3F;
      end
      tick();
      if (last_acc) bus.data_vld = 1'b0;
      if (sel !== e_sel) begin errors++; $display("FAIL rsm_pre_sel k=%0d got %h exp %h", k, sel, e_sel); end
      checks++;
      if (p_full && k % FRAME == 35) hit = 1;
    end
    if (!hit) begin errors++; $display("FAIL rsm_setup got timeout exp digit3 with pending"); end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (sel !== 6'h3F) begin errors++; $display("FAIL rsm_sel got %h exp 3f", sel); end
    if (dig !== 8'hFF) begin errors++; $display("FAIL rsm_dig got %h exp ff", dig); end
    if (bus.data_rdy !== 1'b1) begin errors++; $display("FAIL rsm_rdy got %b exp 1", bus.data_rdy); end
    checks += 3;
    for (int c = 0; c < 130; c++) begin
      tick();
      if (sel !== e_sel) begin errors++; $display("FAIL rsm_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL rsm_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL rsm_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL rsm_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
      // display must be back to the default zeros, not the discarded value
      if (sel !== 6'h3F && dig !== 8'hC0) begin errors++; $display("FAIL rsm_zero k=%0d got %h exp c0", k, dig); end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if (bus.data_vld !== 1'b1 && $urandom_range(0, 39) == 0) begin
        bus.data_vld = 1'b1;
        bus.data_val = ($urandom_range(0, 2) == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
        bus.data_en  = 6'($urandom);
        bus.data_dp  = 6'($urandom);
      end
      if ($urandom_range(0, 96) == 0) lzb = ~lzb;
      tick();
      if (last_acc) bus.data_vld = 1'b0;
      if (sel !== e_sel) begin errors++; $display("FAIL rnd_sel k=%0d got %h exp %h", k, sel, e_sel); end
      if (dig !== e_dig) begin errors++; $display("FAIL rnd_dig k=%0d got %h exp %h", k, dig, e_dig); end
      if (fd !== e_fd) begin errors++; $display("FAIL rnd_fd k=%0d got %b exp %b", k, fd, e_fd); end
      if (bus.data_rdy !== !p_full) begin errors++; $display("FAIL rnd_rdy k=%0d got %b exp %b", k, bus.data_rdy, !p_full); end
      checks += 4;
    end
    bus.data_vld = 1'b0;
    lzb = 1'b0;
  endtask

  initial begin
    bus.data_vld = 1'b0;
    bus.data_val = '0;
    bus.data_en  = '0;
    bus.data_dp  = '0;
    test_reset();
    test_idle();
    test_write_midframe();
    test_lzb();
    test_back_to_back();
    test_en_mask();
    test_reset_mid_show();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 6-digit common-anode 7-segment display.
- Accepts a 24-bit hex value, per-digit enable mask and decimal-point mask through a valid/ready handshake.
- Double-buffers the value so updates land only on frame boundaries, with no tearing.
- Sequences digit selects with an inter-digit blanking gap (ghost suppression) and optional leading-zero blanking; drives dig/sel pins directly.

Parameters:
- SCAN_CYC, 50_000, clock cycles per digit slot including blanking (1 ms at 50 MHz); must exceed BLANK_CYC
- BLANK_CYC, 500, cycles at slot start with all digits off
- NDIG, 6, number of digits (fixed at 6 for this board; parameter kept for package sizing)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- data_vld  in  1  update request
- data_rdy  out  1  pending buffer free; transfer occurs when data_vld & data_rdy
- data_val  in  24  hex value; nibble k drives digit k, digit 0 rightmost
- data_en  in  6  per-digit enable, 1 = show
- data_dp  in  6  per-digit decimal point, 1 = lit
- lzb  in  1  leading-zero blanking enable (sampled live)
- frame_done  out  1  one-cycle pulse at end of digit 5 slot
- dig  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- sel  out  6  digit select, active-low one-hot; all-ones = off

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=BLANK, idx=0, slot counter=0.
  - Active buffer: value 0, en 6'h3F, dp 0; pending buffer empty.
  - Outputs: dig=8'hFF, sel=6'h3F, data_rdy=1, frame_done=0.
  - Reset mid-frame aborts immediately; any pending data is discarded.
- FSM states:
  - BLANK: counter 0..BLANK_CYC-1; sel=6'h3F, dig=8'hFF. At BLANK_CYC-1, go to SHOW.
  - SHOW: counter BLANK_CYC..SCAN_CYC-1; drive digit idx. At SCAN_CYC-1, counter resets to 0, idx advances, go to BLANK.
- Slot sequencing:
  - idx runs 0→5 and wraps 5→0. The wrap cycle is the frame boundary.
  - A full frame is exactly 6*SCAN_CYC cycles.
- Outputs are registered. sel/dig reflect state and idx one cycle after the counter transition.
- In SHOW:
  - sel = ~(6'b1 << idx).
  - dig = ~{dp[idx], seg7(nibble idx)}, using the standard hex glyphs 0-F.
  - Disabled or blanked digit: sel stays deasserted (6'h3F) for the slot. The slot is still consumed, so brightness stays constant.
- Leading-zero blanking (lzb=1):
  - Let m = index of the highest nonzero nibble of the active value (m=0 if the value is 0).
  - Digits idx>m are blanked.
  - Digit 0 is always shown if enabled.
  - dp on a blanked digit is also suppressed.
- Handshake:
  - data_rdy = ~pend_full (registered).
  - On vld&rdy, latch {val,en,dp} into pending and set pend_full.
  - At the frame boundary with pend_full: copy pending→active, clear pend_full. data_rdy rises the following cycle.
  - An accept in the boundary cycle itself, with pending empty, is not transferred until the next frame.
  - Latency from accept to first visible digit: ≤1 frame + BLANK_CYC + 1 cycles.
- frame_done:
  - Asserted the cycle after the idx 5→0 wrap, coincident with the active-buffer load.
  - Never asserted during rst.
- data_vld held high with data_rdy=0: no effect, no loss; the requester holds the data.

Decomposition:
- Package seg_pkg:
  - glyph constants ZER..NIN, A..F (8'h active-low codes);
  - SEG_OFF=8'hFF, SEL_OFF=6'h3F;
  - state enum {BLANK, SHOW};
  - function seg7(nibble)→7-bit pattern.
- One natural sub-module: seg_dec (4-bit nibble + dp → 8-bit active-low segments), reusable by other display blocks.
- Scan FSM, buffers and leading-zero logic stay in seg_scan_ctrl.

Test Plan:
- All cases use SCAN_CYC=10, BLANK_CYC=2.
- Reset, then 120 cycles idle, default buffers:
  - each slot shows 2 cycles sel=3F, then 8 cycles sel active on idx 0..5 in order, dig=ZER (8'hC0);
  - frame_done pulses every 60 cycles.
- Write val=24'h12AB3F, en=3F, dp=6'b000100 mid-frame:
  - data_rdy drops the next cycle;
  - the current frame still shows 0s;
  - the next frame shows digit0=F(8'h8E), digit1=3(8'hB0), digit2=B with dp (8'h03), digit3=A(8'h88), digit4=2(8'hA4), digit5=1(8'hF9);
  - data_rdy returns high after the boundary.
- lzb=1, val=24'h000042:
  - digits 2..5 keep sel=3F in their SHOW window;
  - digit1=4(8'h99), digit0=2;
  - with val=0, only digit 0 is lit with ZER.
- Back-to-back writes:
  - the second vld is stalled (rdy=0) until the frame boundary;
  - the displayed sequence is first value for one frame, then second value;
  - no write is lost or duplicated.
- en=6'b101010: slots 0, 2, 4 keep sel=3F throughout, and frame length is still 60 cycles.
- Assert rst for 1 cycle mid-SHOW of digit 3 with pending full:
  - next cycle: sel=3F, dig=FF, data_rdy=1, idx restarts at 0;
  - display returns to 0s and pending data is discarded.
